// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM states, recode pairs
// and the width helper for the iteration counter.
package booth_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // {Q[0], q_1} patterns that require an add or a subtract of M.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Bits needed to hold the value w (i.e. ceil(log2(w+1))).
    function automatic int count_width(input int w);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < (w + 1)) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/booth_addsub.sv
// N-bit adder/subtractor: S = A + B when m=0, A - B when m=1 (B inverted, carry-in m).
module booth_addsub #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_m,
    output logic [N-1:0] o_s,
    output logic         o_ca_out
);

    logic [N-1:0] w_b_x;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bx
            assign w_b_x[gi] = i_b[gi] ^ i_m;
        end
    endgenerate

    assign {o_ca_out, o_s} = {1'b0, i_a} + {1'b0, w_b_x} + {{N{1'b0}}, i_m};

endmodule

// File: rtl/booth_mul4.sv
// Sequential radix-2 Booth signed multiplier: WIDTH iterations through booth_addsub,
// start/busy/done handshake, product held until the next completion.
module booth_mul4
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = count_width(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH:0]     r_ac;
    logic [WIDTH:0]     r_m;
    logic [WIDTH-1:0]   r_q;
    logic               r_q1;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [1:0]         w_pair;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;
    logic               w_ca_unused;
    logic [WIDTH:0]     w_ac_next;
    logic [WIDTH:0]     w_ac_sh;
    logic [WIDTH-1:0]   w_q_sh;
    logic               w_load;
    logic               w_last;

    assign w_pair = {r_q[0], r_q1};
    assign w_sub  = (w_pair == BOOTH_SUB);

    booth_addsub #(
        .N (WIDTH + 1)
    ) u_addsub (
        .i_a      (r_ac),
        .i_b      (r_m),
        .i_m      (w_sub),
        .o_s      (w_sum),
        .o_ca_out (w_ca_unused)
    );

    // 00/11 leave AC untouched; the carry-out is not needed since AC has a guard bit.
    assign w_ac_next = ((w_pair == BOOTH_ADD) || (w_pair == BOOTH_SUB)) ? w_sum : r_ac;
    assign w_ac_sh   = {w_ac_next[WIDTH], w_ac_next[WIDTH:1]};
    assign w_q_sh    = {w_ac_next[0], r_q[WIDTH-1:1]};

    assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last = (r_state == S_RUN) && (r_count == CW'(1));

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ac      <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_ac    <= '0;
                r_q     <= mplier;
                r_q1    <= 1'b0;
                r_m     <= {mcand[WIDTH-1], mcand};
                r_count <= CW'(WIDTH);
            end else if (r_state == S_RUN) begin
                r_ac    <= w_ac_sh;
                r_q     <= w_q_sh;
                r_q1    <= r_q[0];
                r_count <= r_count - CW'(1);
            end
            if (w_last) begin
                r_product <= {w_ac_sh[WIDTH-1:0], w_q_sh};
            end
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_mul4.sv
// Self-checking bench for booth_mul4: cycle-level behavioural model plus directed
// literal checks, exhaustive operand sweep and a randomized start/reset phase.
module tb_booth_mul4;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int n_cmp  = 0;
    int n_fail = 0;
    bit en_cmp = 1'b0;

    // Behavioural model: cycles of RUN left, pending product, visible outputs.
    int             m_run_left = 0;
    logic [2*W-1:0] m_pend = '0;
    logic [2*W-1:0] m_prod = '0;
    logic           m_done = 1'b0;

    booth_mul4 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return (2*W)'(ia * ib);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_run_left = 0;
            m_done     = 1'b0;
            m_prod     = '0;
        end else if (m_run_left == 0) begin
            m_done = 1'b0;
            if (start) begin
                m_pend     = ref_mul(mcand, mplier);
                m_run_left = W;
            end
        end else begin
            m_run_left--;
            m_done = (m_run_left == 0);
            if (m_run_left == 0) begin
                m_prod = m_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (en_cmp) begin
            check("busy", 16'(busy), 16'(m_run_left > 0));
            check("done", 16'(done), 16'(m_done));
            check("product", 16'(product), 16'(m_prod));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One multiply with a single-cycle start; returns product at done and busy cycles seen.
    task automatic run_one(input logic [W-1:0] mc, input logic [W-1:0] mp,
                           output logic [2*W-1:0] prod, output int busy_cycles);
        bit got;
        got = 1'b0;
        busy_cycles = 0;
        prod = '0;
        start  = 1'b1;
        mcand  = mc;
        mplier = mp;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                got  = 1'b1;
                prod = product;
                break;
            end
        end
        if (!got) check("done_timeout", 16'd0, 16'd1);
        tick();
    endtask

    initial begin
        logic [2*W-1:0] p;
        int             bc;
        int             gap;
        int             n_done;
        bit             got;

        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_product", 16'(product), 16'd0);
        en_cmp = 1'b1;

        run_one(4'd3, 4'd1, p, bc);
        $display("3 x 1 -> %02h busy_cycles=%0d", p, bc);
        check("p_3x1", 16'(p), 16'h03);
        check("busy_cycles", 16'(bc), 16'd4);
        run_one(4'h8, 4'h8, p, bc);
        $display("-8 x -8 -> %02h", p);
        check("p_m8xm8", 16'(p), 16'h40);
        run_one(4'd7, 4'h8, p, bc);
        $display("7 x -8 -> %02h", p);
        check("p_7xm8", 16'(p), 16'hC8);
        run_one(4'd0, 4'd5, p, bc);
        $display("0 x 5 -> %02h", p);
        check("p_0x5", 16'(p), 16'h00);
        run_one(4'hF, 4'hF, p, bc);
        $display("-1 x -1 -> %02h", p);
        check("p_m1xm1", 16'(p), 16'h01);

        // Back-to-back with start held; operands change mid-RUN.
        start = 1'b1; mcand = 4'd2; mplier = 4'd3;
        tick();
        tick();
        tick();
        mcand = 4'hD; mplier = 4'd5;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        if (!got) check("b2b_timeout1", 16'd0, 16'd1);
        $display("b2b first -> %02h", product);
        check("b2b_first", 16'(product), 16'h06);
        @(posedge clk);
        #1;
        start = 1'b0;
        gap = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
            gap++;
        end
        if (!got) check("b2b_timeout2", 16'd0, 16'd1);
        $display("b2b second -> %02h gap=%0d", product, gap);
        check("b2b_second", 16'(product), 16'hF1);
        check("b2b_gap", 16'(gap), 16'd5);
        tick();

        // Reset two cycles into RUN.
        start = 1'b1; mcand = 4'd5; mplier = 4'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 16'(busy), 16'd0);
        check("midrst_done", 16'(done), 16'd0);
        check("midrst_product", 16'(product), 16'd0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        $display("mid-run reset: done pulses after = %0d", n_done);
        check("midrst_no_done", 16'(n_done), 16'd0);
        tick();

        // Exhaustive operand sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_one(4'(a), 4'(b), p, bc);
                $display("sweep %0d x %0d -> %02h", $signed(4'(a)), $signed(4'(b)), p);
                check("sweep", 16'(p), 16'(ref_mul(4'(a), 4'(b))));
            end
        end

        // Random start/operand/reset traffic, checked every cycle by the model.
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 3) != 0);
            mcand  = W'($urandom);
            mplier = W'($urandom);
            rst    = ($urandom_range(0, 49) == 0);
            tick();
            if (done) $display("rand done -> %02h", product);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mul4.md
# booth_mul4

Sequential signed multiplier that sequences the team's add/subtract datapath with radix-2 Booth recoding. It takes two WIDTH-bit two's-complement operands and returns a 2·WIDTH-bit signed product after a fixed number of cycles. It sits directly around the add/sub stage: it drives that stage's A/B/m inputs every iteration and consumes its sum/difference output. It exposes a start/busy/done handshake to the surrounding control.

## Interface
- WIDTH, 4, operand width in bits; legal values 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- mcand  input  WIDTH  signed multiplicand M; captured on an accepted start.
- mplier  input  WIDTH  signed multiplier Q; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product is valid from this cycle.
- product  output  2·WIDTH  signed product; held until the next accepted start.

## Operation
- Reset values:
  - state = IDLE.
  - busy = 0, done = 0, product = 0.
  - All internal registers (AC, Q, q_1, M, count) = 0.
- Internal registers:
  - AC: WIDTH+1 bits, signed. The extra bit prevents overflow when M = −2^(WIDTH−1).
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - count: ceil(log2(WIDTH+1)) bits.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1: load AC=0, Q=mplier, q_1=0, M=sext(mcand), count=WIDTH; go to RUN.
  - RUN, each cycle, using the add/sub result (S) on {Q[0], q_1}:
    - 01: AC' = AC + M (m=0).
    - 10: AC' = AC − M (m=1).
    - 00 or 11: AC' = AC.
  - RUN, same cycle: arithmetic shift right of {AC', Q, q_1} by one, sign bit replicated; count decrements.
  - RUN, count=1: perform the final iteration; write product = {AC'[WIDTH−1:0], Q'} after the shift; go to DONE.
  - DONE: done=1 for exactly this cycle.
    - start=1: reload as in IDLE and go to RUN (back-to-back).
    - start=0: go to IDLE.
- start is ignored while in RUN; operands are not re-sampled.
- The add/sub carry-out is unused; AC width alone guarantees correctness.
- Full signed range is exact, including −2^(WIDTH−1) × −2^(WIDTH−1) = +2^(2·WIDTH−2).

## Timing
- Start sampled at edge E0.
- busy is high from E0 through E0+WIDTH.
- done pulses in the cycle after edge E0+WIDTH.
- Latency: WIDTH+1 cycles from start to done (5 for WIDTH=4).
- Throughput with start held high: one product every WIDTH+1 cycles.
- product changes only at the final RUN edge. It is stable from the done cycle until the next completion; a new start does not clear it.
- rst asserted in any state, including mid-RUN: the next edge restores all reset values. The partial result is discarded and no done pulse is issued.
- rst and start high in the same cycle: rst wins.

## Structure
- Shared package `booth_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the Booth recode constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10);
  - a count-width function.
- One sub-module, `booth_addsub`:
  - parameterized (WIDTH+1)-bit version of the team add/sub;
  - same port semantics: A, B, m (0=add, 1=sub), S, ca_out;
  - subtraction implemented as B XOR m with carry-in m.
- Top level: FSM plus AC/Q/q_1/M/count registers only.

## Test plan
- mcand=3, mplier=1, start for 1 cycle → done after 5 cycles, product=8'h03; busy high for 4 cycles before done.
- mcand=−8, mplier=−8 → product=8'h40 (+64), no overflow.
- mcand=7, mplier=−8 → product=8'hC8 (−56); mcand=0, mplier=5 → 8'h00; mcand=−1, mplier=−1 → 8'h01.
- start=1 held with 2×3, then operands changed to −3×5 during RUN → first product 8'h06 (operands not re-sampled), second product 8'hF1 (−15) exactly 5 cycles later.
- rst asserted 2 cycles into RUN → next cycle: busy=0, done=0, product=0, state IDLE; no done pulse follows.
- Exhaustive sweep of all 256 operand pairs for WIDTH=4 against a signed reference multiply.
